// File: rtl/sci_cmd_arbiter.sv
// SCI write arbiter: merges volume and song-change (soft reset) requests into one
// ordered stream of codec register writes over a start/done handshake gated by DREQ.
module sci_cmd_arbiter #(
    parameter logic [15:0] MODE_RESET_VAL = 16'h0804,
    parameter logic [15:0] MODE_NORM_VAL  = 16'h0800,
    parameter logic [15:0] CLOCKF_VAL     = 16'h9800,
    parameter logic [15:0] VOL_INIT       = 16'h0000,
    parameter int unsigned SETTLE_CYC     = 100,
    parameter int unsigned DREQ_TIMEOUT   = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_vol_req,
    input  logic [15:0] i_vol_val,
    input  logic        i_rst_req,
    input  logic        i_dreq,
    input  logic        i_sci_done,
    output logic        o_sci_start,
    output logic [7:0]  o_sci_addr,
    output logic [15:0] o_sci_data,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_err
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_WAIT_DREQ = 2'd3;

    localparam logic [7:0] ADDR_MODE   = 8'h00;
    localparam logic [7:0] ADDR_CLOCKF = 8'h03;
    localparam logic [7:0] ADDR_VOL    = 8'h0B;

    // The reset write is the normal mode word with the soft-reset bits flipped.
    localparam logic [15:0] L_SOFT_RST_BITS = MODE_RESET_VAL ^ MODE_NORM_VAL;

    localparam logic [31:0] L_SETTLE   = 32'(SETTLE_CYC);
    localparam logic [31:0] L_TO_ISSUE = 32'(DREQ_TIMEOUT);
    localparam logic [31:0] L_TO_DREQ  = 32'(SETTLE_CYC + DREQ_TIMEOUT);

    logic [1:0]  r_state;
    logic [1:0]  r_step;
    logic        r_seq_rst;
    logic        r_pend_rst;
    logic        r_pend_vol;
    logic [15:0] r_vol_shadow;
    logic [31:0] r_cnt;

    logic [1:0]  w_state_nxt;
    logic [1:0]  w_step_nxt;
    logic        w_seq_rst_nxt;
    logic        w_start;
    logic        w_err;
    logic        w_clr_rst;
    logic        w_clr_vol;
    logic        w_init_set;
    logic [31:0] w_cnt_limit;
    logic        w_cnt_run;
    logic [7:0]  w_addr;
    logic [15:0] w_data;

    // Step 0/1/2 map to MODE/CLOCKF/VOL; a volume sequence is just step 2.
    always_comb begin
        w_addr = ADDR_VOL;
        w_data = r_vol_shadow;
        case (r_step)
            2'd0: begin
                w_addr = ADDR_MODE;
                w_data = MODE_NORM_VAL ^ L_SOFT_RST_BITS;
            end
            2'd1: begin
                w_addr = ADDR_CLOCKF;
                w_data = CLOCKF_VAL;
            end
            default: begin
                w_addr = ADDR_VOL;
                w_data = r_vol_shadow;
            end
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step;
        w_seq_rst_nxt = r_seq_rst;
        w_start       = 1'b0;
        w_err         = 1'b0;
        w_clr_rst     = 1'b0;
        w_clr_vol     = 1'b0;
        w_init_set    = 1'b0;
        w_cnt_limit   = (r_state == S_WAIT_DREQ) ? L_TO_DREQ : L_TO_ISSUE;
        w_cnt_run     = (r_state == S_ISSUE) || (r_state == S_WAIT_DREQ);
        case (r_state)
            S_IDLE: begin
                if (r_pend_rst) begin
                    w_clr_rst     = 1'b1;
                    w_seq_rst_nxt = 1'b1;
                    w_step_nxt    = 2'd0;
                    w_state_nxt   = S_ISSUE;
                end else if (r_pend_vol) begin
                    w_seq_rst_nxt = 1'b0;
                    w_step_nxt    = 2'd2;
                    w_state_nxt   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_dreq) begin
                    w_start     = 1'b1;
                    w_clr_vol   = (r_step == 2'd2);
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == w_cnt_limit) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (i_sci_done) begin
                    if (r_seq_rst && (r_step == 2'd0)) begin
                        w_step_nxt  = 2'd1;
                        w_state_nxt = S_WAIT_DREQ;
                    end else if (r_step != 2'd2) begin
                        w_step_nxt  = r_step + 2'd1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_init_set  = r_seq_rst;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT_DREQ: begin
                if ((r_cnt >= L_SETTLE) && i_dreq) begin
                    w_state_nxt = S_ISSUE;
                end else if (r_cnt == w_cnt_limit) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_step    <= 2'd0;
            r_seq_rst <= 1'b0;
            r_cnt     <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_seq_rst <= w_seq_rst_nxt;
            if ((w_state_nxt != r_state) || !w_cnt_run) begin
                r_cnt <= 32'd0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    // A new request in the same cycle as the clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_rst   <= 1'b1;
            r_pend_vol   <= 1'b0;
            r_vol_shadow <= VOL_INIT;
        end else begin
            if (i_rst_req) begin
                r_pend_rst <= 1'b1;
            end else if (w_clr_rst) begin
                r_pend_rst <= 1'b0;
            end
            if (i_vol_req) begin
                r_pend_vol   <= 1'b1;
                r_vol_shadow <= i_vol_val;
            end else if (w_clr_vol) begin
                r_pend_vol <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sci_start <= 1'b0;
            o_sci_addr  <= 8'h00;
            o_sci_data  <= 16'h0000;
            o_busy      <= 1'b0;
            o_init_done <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_sci_start <= w_start;
            o_busy      <= (w_state_nxt != S_IDLE);
            o_err       <= w_err;
            if (w_start) begin
                o_sci_addr <= w_addr;
                o_sci_data <= w_data;
            end
            if (w_init_set) begin
                o_init_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sci_cmd_arbiter.sv
// Directed bench for sci_cmd_arbiter: a table of single volume writes plus
// hand-written sequences for power-up, coalescing, priority, reset and timeout.
module tb_sci_cmd_arbiter;

    localparam int SETTLE = 20;
    localparam int TMO    = 200;
    localparam int ACK    = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_vol_req = 1'b0;
    logic [15:0] i_vol_val = 16'h0000;
    logic        i_rst_req = 1'b0;
    logic        i_dreq = 1'b1;
    logic        i_sci_done = 1'b0;
    logic        o_sci_start;
    logic [7:0]  o_sci_addr;
    logic [15:0] o_sci_data;
    logic        o_busy;
    logic        o_init_done;
    logic        o_err;

    sci_cmd_arbiter #(
        .SETTLE_CYC   (SETTLE),
        .DREQ_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_vol_req   (i_vol_req),
        .i_vol_val   (i_vol_val),
        .i_rst_req   (i_rst_req),
        .i_dreq      (i_dreq),
        .i_sci_done  (i_sci_done),
        .o_sci_start (o_sci_start),
        .o_sci_addr  (o_sci_addr),
        .o_sci_data  (o_sci_data),
        .o_busy      (o_busy),
        .o_init_done (o_init_done),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [15:0] vol;
        logic [7:0]  exp_addr;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    wr_t  wlog[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   viol = 0;
    int   errs = 0;
    int   err_cyc = 0;
    bit   ack_en = 1'b1;
    int   ack_cnt = 0;
    bit   prev_start = 1'b0;
    bit   outstanding = 1'b0;
    logic [7:0]  cap_addr = 8'h00;
    logic [15:0] cap_data = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-engine model and protocol monitor, both on the falling edge.
    always @(negedge clk) begin
        i_sci_done = 1'b0;
        if (rst) begin
            ack_cnt     = 0;
            outstanding = 1'b0;
            prev_start  = 1'b0;
        end else begin
            if (o_sci_start && prev_start) viol++;
            if (outstanding && ((o_sci_addr !== cap_addr) || (o_sci_data !== cap_data))) viol++;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    i_sci_done  = 1'b1;
                    outstanding = 1'b0;
                end
            end
            if (o_sci_start) begin
                wlog.push_back('{addr: o_sci_addr, data: o_sci_data, cyc: cyc});
                outstanding = 1'b1;
                cap_addr    = o_sci_addr;
                cap_data    = o_sci_data;
                if (ack_en) ack_cnt = ACK;
            end
            if (o_err) begin
                errs++;
                err_cyc = cyc;
            end
            prev_start = o_sci_start;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (wlog.size() >= n) break;
            tick();
        end
        chk(name, 32'(wlog.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int quiet = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!o_busy && !outstanding) quiet++;
            else quiet = 0;
            if (quiet >= 4) break;
        end
        chk(name, 32'(quiet >= 4), 32'd1);
    endtask

    task automatic chk_wr(input string name, input int idx, input logic [7:0] a, input logic [15:0] d);
        if (wlog.size() > idx) begin
            chk({name, "_addr"}, 32'(wlog[idx].addr), 32'(a));
            chk({name, "_data"}, 32'(wlog[idx].data), 32'(d));
        end else begin
            chk({name, "_missing"}, 32'(wlog.size()), 32'(idx + 1));
        end
    endtask

    vec_t vecs[5];

    initial begin
        int gap;
        int base;
        int errs0;

        vecs[0] = '{vol: 16'h1C1C, exp_addr: 8'h0B, exp_data: 16'h1C1C, exp_lat: 3};
        vecs[1] = '{vol: 16'h0000, exp_addr: 8'h0B, exp_data: 16'h0000, exp_lat: 3};
        vecs[2] = '{vol: 16'hFFFF, exp_addr: 8'h0B, exp_data: 16'hFFFF, exp_lat: 3};
        vecs[3] = '{vol: 16'hA55A, exp_addr: 8'h0B, exp_data: 16'hA55A, exp_lat: 3};
        vecs[4] = '{vol: 16'h0001, exp_addr: 8'h0B, exp_data: 16'h0001, exp_lat: 3};

        // Reset state
        tick(); tick(); tick();
        chk("rst_start", 32'(o_sci_start), 32'd0);
        chk("rst_addr", 32'(o_sci_addr), 32'd0);
        chk("rst_data", 32'(o_sci_data), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_init_done", 32'(o_init_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);

        // Power-up init sequence
        rst = 1'b0;
        wait_idle(400, "pwrup_complete");
        chk("pwrup_count", 32'(wlog.size()), 32'd3);
        chk_wr("pwrup_w0", 0, 8'h00, 16'h0804);
        chk_wr("pwrup_w1", 1, 8'h03, 16'h9800);
        chk_wr("pwrup_w2", 2, 8'h0B, 16'h0000);
        if (wlog.size() >= 3) begin
            gap = wlog[1].cyc - wlog[0].cyc;
            chk("pwrup_settle_gap", 32'((gap >= ACK + 2 + SETTLE) && (gap <= ACK + 4 + SETTLE)), 32'd1);
            chk("pwrup_step_gap", 32'(wlog[2].cyc - wlog[1].cyc), 32'(ACK + 2));
        end
        chk("pwrup_init_done", 32'(o_init_done), 32'd1);
        chk("pwrup_busy", 32'(o_busy), 32'd0);

        // Table: single volume writes from idle
        foreach (vecs[k]) begin
            wlog.delete();
            i_vol_req = 1'b1;
            i_vol_val = vecs[k].vol;
            base = cyc;
            tick();
            i_vol_req = 1'b0;
            i_vol_val = 16'h0000;
            wait_writes(1, 20, $sformatf("vec%0d_start", k));
            if (wlog.size() >= 1) begin
                chk($sformatf("vec%0d_lat", k), 32'(wlog[0].cyc - base), 32'(vecs[k].exp_lat));
                chk($sformatf("vec%0d_addr", k), 32'(wlog[0].addr), 32'(vecs[k].exp_addr));
                chk($sformatf("vec%0d_data", k), 32'(wlog[0].data), 32'(vecs[k].exp_data));
            end
            wait_idle(100, $sformatf("vec%0d_idle", k));
            chk($sformatf("vec%0d_count", k), 32'(wlog.size()), 32'd1);
        end

        // Three volume pulses while a write is in flight coalesce to the last value
        wlog.delete();
        i_vol_req = 1'b1; i_vol_val = 16'h1111;
        tick();
        i_vol_req = 1'b0;
        wait_writes(1, 20, "coal_first_start");
        tick();
        i_vol_req = 1'b1; i_vol_val = 16'h0E0E; tick();
        i_vol_val = 16'h1C1C; tick();
        i_vol_val = 16'h2A2A; tick();
        i_vol_req = 1'b0; i_vol_val = 16'h0000;
        wait_idle(200, "coal_idle");
        chk("coal_count", 32'(wlog.size()), 32'd2);
        chk_wr("coal_w0", 0, 8'h0B, 16'h1111);
        chk_wr("coal_w1", 1, 8'h0B, 16'h2A2A);

        // Reset and volume request in the same idle cycle: volume rides in step2
        wlog.delete();
        i_rst_req = 1'b1;
        i_vol_req = 1'b1; i_vol_val = 16'h3838;
        tick();
        i_rst_req = 1'b0; i_vol_req = 1'b0; i_vol_val = 16'h0000;
        wait_idle(400, "prio_idle");
        chk("prio_count", 32'(wlog.size()), 32'd3);
        chk_wr("prio_w0", 0, 8'h00, 16'h0804);
        chk_wr("prio_w1", 1, 8'h03, 16'h9800);
        chk_wr("prio_w2", 2, 8'h0B, 16'h3838);

        // rst asserted while a write is outstanding
        wlog.delete();
        ack_en = 1'b0;
        i_vol_req = 1'b1; i_vol_val = 16'h4242;
        tick();
        i_vol_req = 1'b0; i_vol_val = 16'h0000;
        wait_writes(1, 20, "midrst_start");
        tick(); tick();
        chk("midrst_pre_busy", 32'(o_busy), 32'd1);
        chk("midrst_pre_addr", 32'(o_sci_addr), 32'h0B);
        chk("midrst_pre_init", 32'(o_init_done), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_addr", 32'(o_sci_addr), 32'd0);
        chk("midrst_data", 32'(o_sci_data), 32'd0);
        chk("midrst_start", 32'(o_sci_start), 32'd0);
        chk("midrst_init", 32'(o_init_done), 32'd0);
        chk("midrst_err", 32'(o_err), 32'd0);
        tick(); tick();
        wlog.delete();
        ack_en = 1'b1;
        rst = 1'b0;
        wait_writes(1, 20, "restart_start");
        chk_wr("restart_w0", 0, 8'h00, 16'h0804);

        // DREQ stuck low after the MODE write: timeout abort
        i_dreq = 1'b0;
        errs0 = errs;
        for (int i = 0; i < 400; i++) begin
            if (errs != errs0) break;
            tick();
        end
        chk("tmo_seen", 32'(errs != errs0), 32'd1);
        if ((errs != errs0) && (wlog.size() >= 1)) begin
            gap = err_cyc - (wlog[0].cyc + ACK);
            chk("tmo_time", 32'((gap >= SETTLE + TMO) && (gap <= SETTLE + TMO + 2)), 32'd1);
        end
        for (int i = 0; i < 60; i++) tick();
        chk("tmo_err_once", 32'(errs - errs0), 32'd1);
        chk("tmo_busy", 32'(o_busy), 32'd0);
        chk("tmo_init_done", 32'(o_init_done), 32'd0);
        chk("tmo_no_more_writes", 32'(wlog.size()), 32'd1);

        chk("protocol_violations", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
